// File: rtl/gpr_port_ctrl.sv
// Operand read sequencer (rs1 then rs2) and two-way round-robin write arbiter for a 1R1W GPR file.
// Latency: operands valid 2 cycles after acceptance (3 with rs2); write grant is same-cycle combinational.
// Backpressure: one read in flight, rd_req_ready low until the response is taken; writers hold until ready.
module gpr_port_ctrl #(
   parameter int XLEN       = 32,
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_req_valid,
   output logic            rd_req_ready,
   input  logic [4:0]      rd_rs1,
   input  logic [4:0]      rd_rs2,
   input  logic            rd_need_rs2,
   output logic            rd_resp_valid,
   input  logic            rd_resp_ready,
   output logic [XLEN-1:0] rd_src1,
   output logic [XLEN-1:0] rd_src2,
   input  logic            wb0_valid,
   output logic            wb0_ready,
   input  logic [4:0]      wb0_addr,
   input  logic [XLEN-1:0] wb0_data,
   input  logic            wb1_valid,
   output logic            wb1_ready,
   input  logic [4:0]      wb1_addr,
   input  logic [XLEN-1:0] wb1_data,
   output logic [4:0]      gpr_r1,
   input  logic [XLEN-1:0] gpr_rd1,
   output logic            gpr_we,
   output logic [4:0]      gpr_writer,
   output logic [XLEN-1:0] gpr_wd
);

   typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       need_rs2;
   } rd_req_t;

   state_t          state;
   rd_req_t         req_q;
   logic            prio;
   logic            grant0;
   logic            grant1;
   logic [XLEN-1:0] cap_val;

   // prio names the requester that wins when both are valid
   always_comb begin
      grant0 = wb0_valid && (!wb1_valid || !prio);
      grant1 = wb1_valid && !grant0;
   end

   assign wb0_ready = grant0;
   assign wb1_ready = grant1;

   always_comb begin
      gpr_writer = '0;
      gpr_wd     = '0;
      if (grant0) begin
         gpr_writer = wb0_addr;
         gpr_wd     = wb0_data;
      end else if (grant1) begin
         gpr_writer = wb1_addr;
         gpr_wd     = wb1_data;
      end
   end

   assign gpr_we = (grant0 || grant1) && (gpr_writer != 5'd0);

   always_ff @(posedge clk) begin
      if (rst)
         prio <= RESET_PRIO;
      else if (grant0)
         prio <= 1'b1;
      else if (grant1)
         prio <= 1'b0;
   end

   always_comb begin
      gpr_r1 = '0;
      case (state)
         RD1:     gpr_r1 = req_q.rs1;
         RD2:     gpr_r1 = req_q.rs2;
         default: gpr_r1 = '0;
      endcase
   end

   // The file updates only at the edge, so a same-cycle write to the index is taken from the write port.
   always_comb begin
      if (gpr_r1 == 5'd0)
         cap_val = '0;
      else if (gpr_we && (gpr_writer == gpr_r1))
         cap_val = gpr_wd;
      else
         cap_val = gpr_rd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_q         <= '0;
         rd_src1       <= '0;
         rd_src2       <= '0;
         rd_req_ready  <= 1'b1;
         rd_resp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_req_valid) begin
                  req_q        <= '{rs1: rd_rs1, rs2: rd_rs2, need_rs2: rd_need_rs2};
                  rd_req_ready <= 1'b0;
                  state        <= RD1;
               end
            end
            RD1: begin
               rd_src1 <= cap_val;
               if (req_q.need_rs2) begin
                  state <= RD2;
               end else begin
                  rd_src2       <= '0;
                  rd_resp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            RD2: begin
               rd_src2       <= cap_val;
               rd_resp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (rd_resp_ready) begin
                  rd_resp_valid <= 1'b0;
                  rd_req_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/gpr_port_ctrl.md
Name: gpr_port_ctrl

Overview:
- Sequencer and arbiter in front of the single-read, single-write general-purpose register file (x0 hardwired to 0, writes land at the next clock edge).
- Time-multiplexes the one read port to fetch rs1 then rs2 for the decode stage.
- Round-robin arbitrates two write-back requesters (EXU result, LSU load) onto the one write port.
- Forwards same-cycle write data into operand capture.

Parameters:
- XLEN, 32, data width of registers and operands.
- RESET_PRIO, 0, write requester that holds priority after reset (0 = wb0, 1 = wb1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_valid  in  1  operand read request valid
- rd_req_ready  out  1  controller can accept a request
- rd_rs1  in  5  first source register index
- rd_rs2  in  5  second source register index
- rd_need_rs2  in  1  1 = fetch rs2; 0 = src2 returns 0
- rd_resp_valid  out  1  operands valid
- rd_resp_ready  in  1  consumer accepts operands
- rd_src1  out  XLEN  operand 1
- rd_src2  out  XLEN  operand 2
- wb0_valid / wb1_valid  in  1  write-back request
- wb0_ready / wb1_ready  out  1  write-back granted this cycle
- wb0_addr / wb1_addr  in  5  destination index
- wb0_data / wb1_data  in  XLEN  write data
- gpr_r1  out  5  register file read address
- gpr_rd1  in  XLEN  register file read data (combinational)
- gpr_we  out  1  register file write enable
- gpr_writer  out  5  register file write address
- gpr_wd  out  XLEN  register file write data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While rst is high at a clock edge:
  - state <= IDLE
  - rd_src1, rd_src2 <= 0; latched indices and need flag <= 0
  - priority pointer <= RESET_PRIO
- Reset mid-read discards the request; no response is produced.
- Read FSM states: IDLE, RD1, RD2, RESP.
  - IDLE: rd_req_ready=1, gpr_r1=0. On rd_req_valid latch rs1, rs2 and need_rs2, then go to RD1.
  - RD1: gpr_r1=rs1; capture src1. Next state is RD2 if need_rs2, else RESP with src2<=0.
  - RD2: gpr_r1=rs2; capture src2; go to RESP.
  - RESP: rd_resp_valid=1. src1/src2 are held stable while waiting. When rd_resp_ready is high, go to IDLE.
  - rd_req_ready is 0 outside IDLE, so there is no back-to-back acceptance. A new request is accepted the cycle after the RESP handshake.
- Read latency: acceptance at edge N gives rd_resp_valid from cycle N+3 with rs2, N+2 without.
- Operand capture rule (RD1/RD2):
  - Index 0 captures 0.
  - Else, if gpr_we=1 this cycle and gpr_writer equals the index, capture gpr_wd (bypass).
  - Else capture gpr_rd1.
- Write arbiter (combinational grant, one grant per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester holding priority is granted.
  - After any grant, priority moves to the non-granted requester.
  - With no grant, priority is unchanged.
- Write port outputs:
  - wbX_ready=1 only for the granted requester; a requester must hold valid/addr/data until it sees ready.
  - gpr_writer and gpr_wd come from the granted requester; both are 0 when no grant.
  - gpr_we = grant && addr!=0. A write to x0 is granted (ready=1) but suppressed.
- Reads and writes are independent; a write may be granted in any read state.

Test Plan:
- Reset, then rd_req (rs1=5, rs2=6, need=1) with x5=0x11, x6=0x22 → ready drops the next cycle; gpr_r1 shows 5 then 6; resp_valid at N+3 with src1=0x11, src2=0x22.
- rd_req with need_rs2=0, rs1=7 (x7=0xABCD) → resp_valid at N+2, src1=0xABCD, src2=0; only one RD cycle.
- Hold rd_resp_ready=0 for 4 cycles in RESP → resp_valid and src values stable, rd_req_ready=0; accept on cycle 5, then IDLE.
- wb0 and wb1 valid continuously (addrs 3/4, data 0xA/0xB), RESET_PRIO=0 → grants alternate wb0, wb1, wb0…; gpr_we=1 each cycle.
- During RD1 for rs1=9, wb1 writes x9=0x1234 the same cycle → src1=0x1234 (bypass). wb0 writes addr 0 → wb0_ready=1, gpr_we=0.
- Assert rst during RD2 → next cycle IDLE, rd_req_ready=1, no resp_valid, src1/src2=0, priority=RESET_PRIO.
